conv_loop_sequencer: RTL and testbench

CONV_LOOP_SEQUENCER -- requirements
Module: conv_loop_sequencer

---
 rtl/conv_loop_pkg.sv | 13 +
 rtl/loop_digit.sv | 31 +++
 rtl/conv_loop_sequencer.sv | 123 ++++++++++++
 tb/tb_conv_loop_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_loop_pkg.sv
// Shared types for the convolution loop-nest sequencer.
// Holds the FSM state encoding and the default index width.
package conv_loop_pkg;

    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/loop_digit.sv
// One wrapping loop counter for the sequencer carry chain.
// Ports: clk, rst_n, en (carry-in), clr, bound, value, carry (out).
module loop_digit #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] bound,
    output logic [W-1:0] value,
    output logic         carry
);

    logic at_bound;

    assign at_bound = (value == bound);
    // Carry is combinational so the whole chain advances on one edge.
    assign carry    = en & at_bound;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (en) begin
            value <= at_bound ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/conv_loop_sequencer.sv
// Four-deep loop-nest index sequencer (c innermost, i outermost).
// Ports: clk, rst_n, start, abort, c/r/j/i_max bounds, idx_valid,
// idx_ready, c/r/j/i indices, last_* flags, busy, done.
module conv_loop_sequencer
    import conv_loop_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int LAST_FLAGS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] c_max,
    input  logic [CNT_W-1:0] r_max,
    input  logic [CNT_W-1:0] j_max,
    input  logic [CNT_W-1:0] i_max,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [CNT_W-1:0] c,
    output logic [CNT_W-1:0] r,
    output logic [CNT_W-1:0] j,
    output logic [CNT_W-1:0] i,
    output logic             last_c,
    output logic             last_r,
    output logic             last_j,
    output logic             last_i,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [CNT_W-1:0] bnd_c, bnd_r, bnd_j, bnd_i;
    logic             en_c, clr;
    logic             cy_c, cy_r, cy_j, cy_i;

    // Abort outranks a coincident handshake, so it also blocks counting.
    assign en_c = idx_valid & idx_ready & ~abort;
    assign clr  = abort | (state == IDLE);

    loop_digit #(.W(CNT_W)) u_dig_c (
        .clk(clk), .rst_n(rst_n), .en(en_c), .clr(clr),
        .bound(bnd_c), .value(c), .carry(cy_c)
    );
    loop_digit #(.W(CNT_W)) u_dig_r (
        .clk(clk), .rst_n(rst_n), .en(cy_c), .clr(clr),
        .bound(bnd_r), .value(r), .carry(cy_r)
    );
    loop_digit #(.W(CNT_W)) u_dig_j (
        .clk(clk), .rst_n(rst_n), .en(cy_r), .clr(clr),
        .bound(bnd_j), .value(j), .carry(cy_j)
    );
    loop_digit #(.W(CNT_W)) u_dig_i (
        .clk(clk), .rst_n(rst_n), .en(cy_j), .clr(clr),
        .bound(bnd_i), .value(i), .carry(cy_i)
    );

    generate
        if (LAST_FLAGS != 0) begin : g_last
            assign last_c = idx_valid & (c == bnd_c);
            assign last_r = idx_valid & (r == bnd_r);
            assign last_j = idx_valid & (j == bnd_j);
            assign last_i = idx_valid & (i == bnd_i);
        end else begin : g_nolast
            assign last_c = 1'b0;
            assign last_r = 1'b0;
            assign last_j = 1'b0;
            assign last_i = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bnd_c     <= '0;
            bnd_r     <= '0;
            bnd_j     <= '0;
            bnd_i     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        bnd_c     <= c_max;
                        bnd_r     <= r_max;
                        bnd_j     <= j_max;
                        bnd_i     <= i_max;
                        state     <= RUN;
                        idx_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        idx_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (cy_i) begin
                        // Outermost carry means the final tuple was taken.
                        state     <= DONE;
                        idx_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    idx_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Self-checking bench for conv_loop_sequencer.
// Table of run configurations plus reset/abort/idle corner sequences.
module tb_conv_loop_sequencer;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [W-1:0] c_max, r_max, j_max, i_max;
    logic         idx_valid;
    logic         idx_ready;
    logic [W-1:0] c, r, j, i;
    logic         last_c, last_r, last_j, last_i;
    logic         busy;
    logic         done;

    conv_loop_sequencer #(.CNT_W(W), .LAST_FLAGS(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .c_max(c_max), .r_max(r_max), .j_max(j_max), .i_max(i_max),
        .idx_valid(idx_valid), .idx_ready(idx_ready),
        .c(c), .r(r), .j(j), .i(i),
        .last_c(last_c), .last_r(last_r), .last_j(last_j), .last_i(last_i),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cm, rm, jm, im;
        int mode;    // 0 ready always, 1 toggle 1/0, 2 random
        int inject;  // 0 none, 1 start+c_max change, 2 abort
        int exp_cnt;
    } vec_t;

    typedef struct {
        logic [4*W-1:0] tup;   // {i,j,r,c}
        logic [3:0]     lasts; // {li,lj,lr,lc}
    } exp_t;

    vec_t vecs[6];
    exp_t sbq[$];
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4*W-1:0] cur_tup();
        return {i, j, r, c};
    endfunction

    task automatic run_vec(input vec_t v);
        int hs, cycles, budget;
        bit rdy, aborted, finished, prev_stall;
        logic [4*W-1:0] held;
        exp_t e;
        sbq.delete();
        for (int ii = 0; ii <= v.im; ii++)
            for (int jj = 0; jj <= v.jm; jj++)
                for (int rr = 0; rr <= v.rm; rr++)
                    for (int cc = 0; cc <= v.cm; cc++) begin
                        e.tup = {ii[W-1:0], jj[W-1:0], rr[W-1:0], cc[W-1:0]};
                        e.lasts = {ii == v.im, jj == v.jm,
                                   rr == v.rm, cc == v.cm};
                        sbq.push_back(e);
                    end
        @(negedge clk);
        c_max = v.cm[W-1:0];
        r_max = v.rm[W-1:0];
        j_max = v.jm[W-1:0];
        i_max = v.im[W-1:0];
        start = 1'b1;
        idx_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        hs = 0; cycles = 0; aborted = 0; finished = 0; prev_stall = 0;
        held = '0;
        budget = v.exp_cnt * 3 + 20;
        while (cycles < budget) begin
            if (done !== 1'b0) begin
                check("early_done", done, 0);
                finished = 1;
                break;
            end
            if (idx_valid !== 1'b1) begin
                check("valid_in_run", idx_valid, 1);
                break;
            end
            if (prev_stall) check("stall_hold", cur_tup(), held);
            case (v.mode)
                0: rdy = 1'b1;
                1: rdy = (cycles % 2 == 0);
                default: rdy = $urandom_range(0, 1) != 0;
            endcase
            idx_ready = rdy;
            start = 1'b0;
            abort = 1'b0;
            if (v.inject == 1 && hs == 5) begin
                start = 1'b1;
                c_max = 4'd3;
            end
            prev_stall = !rdy;
            held = cur_tup();
            if (rdy) begin
                if (sbq.size() == 0) begin
                    check("extra_tuple", hs, v.exp_cnt);
                    break;
                end
                e = sbq.pop_front();
                check("tuple", cur_tup(), e.tup);
                check("lasts", {last_i, last_j, last_r, last_c}, e.lasts);
                if (v.inject == 2 && hs == 10) begin
                    abort = 1'b1;
                    aborted = 1;
                end
                hs++;
            end
            @(negedge clk);
            cycles++;
            start = 1'b0;
            if (aborted) begin
                abort = 1'b0;
                check("abort_valid", idx_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_idx", cur_tup(), 0);
                finished = 1;
                break;
            end
            if (rdy && sbq.size() == 0) begin
                idx_ready = 1'b0;
                check("done_pulse", done, 1);
                check("done_valid", idx_valid, 0);
                check("done_busy", busy, 1);
                @(negedge clk);
                check("done_clear", done, 0);
                check("idle_busy", busy, 0);
                check("idle_idx", cur_tup(), 0);
                finished = 1;
                break;
            end
        end
        if (!finished) check("run_timeout", cycles, budget + 1);
        check("hs_count", hs, aborted ? 11 : v.exp_cnt);
        idx_ready = 1'b0;
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        vecs[0] = '{cm:1, rm:1, jm:2, im:2, mode:0, inject:0, exp_cnt:36};
        vecs[1] = '{cm:1, rm:1, jm:2, im:2, mode:1, inject:0, exp_cnt:36};
        vecs[2] = '{cm:0, rm:0, jm:0, im:0, mode:0, inject:0, exp_cnt:1};
        vecs[3] = '{cm:3, rm:0, jm:1, im:2, mode:2, inject:0, exp_cnt:24};
        vecs[4] = '{cm:1, rm:1, jm:2, im:2, mode:0, inject:1, exp_cnt:36};
        vecs[5] = '{cm:1, rm:1, jm:2, im:2, mode:0, inject:2, exp_cnt:36};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        idx_ready = 1'b0;
        c_max = '0; r_max = '0; j_max = '0; i_max = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", idx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", cur_tup(), 0);
        rst_n = 1'b1;

        // Abort alone, and start with abort, must both stay idle.
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        check("idle_abort_busy", busy, 0);
        start = 1'b1;
        c_max = 4'd2;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 0);
        check("start_abort_valid", idx_valid, 0);

        for (int k = 0; k < 6; k++) run_vec(vecs[k]);

        // Reset mid-run: outputs drop at once, no done afterwards.
        @(negedge clk);
        c_max = 4'd1; r_max = 4'd1; j_max = 4'd2; i_max = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx_ready = 1'b1;
        repeat (7) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", idx_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_idx", cur_tup(), 0);
        check("async_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idx_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_done", done, 0);
        end
        run_vec(vecs[0]);

        // Full-range bounds exercise the wrap at 2^W-1.
        run_vec('{cm:15, rm:15, jm:15, im:15, mode:0, inject:0,
                  exp_cnt:65536});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
